mac_dp_multi: RTL and testbench

Parametrised, pipelined successor of the single-accumulator MAC datapath. Holds NUM_ACC internal guarded accumulators with per-accumulator sticky overflow flags. Executes the existing MAC opcode set through a 2-stage pipeline with a valid/stall handshake. Sits in the execute stage beside the ALU; the decoder supplies the opcode, accumulator index and operands, and the RF/forwarding logic consumes the result.

---
 rtl/mac_dp_multi_pkg.sv | 61 ++++++
 rtl/mac_round_sat.sv | 50 +++++
 rtl/mac_dp_multi.sv | 217 +++++++++++++++++++++
 tb/tb_mac_dp_multi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_dp_multi_pkg.sv
// mac_dp_multi_pkg
//   Shared encodings for the multi-accumulator MAC datapath: the MAC opcode
//   set, the operand-B scale selections, and small opcode-class helpers.
//   The helpers keep the datapath selection logic readable.
package mac_dp_multi_pkg;

  typedef enum logic [3:0] {
    MAC_NOP        = 4'd0,
    MAC_CLR        = 4'd1,
    MAC_ADD        = 4'd2,
    MAC_SUB        = 4'd3,
    MAC_CMP        = 4'd4,
    MAC_NEG        = 4'd5,
    MAC_ABS        = 4'd6,
    MAC_MOVE       = 4'd7,
    MAC_MOVE_ROUND = 4'd8,
    MAC_MUL        = 4'd9,
    MAC_MAC        = 4'd10,
    MAC_MDM        = 4'd11
  } mac_op_e;

  typedef enum logic [2:0] {
    SCALE_PASS = 3'd0,
    SCALE_SHL1 = 3'd1,
    SCALE_SHL2 = 3'd2,
    SCALE_SHL3 = 3'd3,
    SCALE_SHR1 = 3'd4,
    SCALE_SHR2 = 3'd5,
    SCALE_SHR3 = 3'd6,
    SCALE_SHR4 = 3'd7
  } scale_e;

  // Encodings above MAC_MDM are treated like NOP: no result, no write.
  function automatic logic op_active(input logic [3:0] op);
    return op inside {MAC_CLR, MAC_ADD, MAC_SUB, MAC_CMP, MAC_NEG, MAC_ABS,
                      MAC_MOVE, MAC_MOVE_ROUND, MAC_MUL, MAC_MAC, MAC_MDM};
  endfunction

  function automatic logic op_uses_operandb(input logic [3:0] op);
    return op inside {MAC_ADD, MAC_SUB, MAC_CMP, MAC_NEG, MAC_ABS,
                      MAC_MOVE, MAC_MOVE_ROUND};
  endfunction

  function automatic logic op_uses_product(input logic [3:0] op);
    return op inside {MAC_MUL, MAC_MAC, MAC_MDM};
  endfunction

  function automatic logic op_reads_acc(input logic [3:0] op);
    return op inside {MAC_ADD, MAC_SUB, MAC_CMP, MAC_MAC, MAC_MDM};
  endfunction

  function automatic logic op_inverts_b(input logic [3:0] op);
    return op inside {MAC_SUB, MAC_CMP, MAC_NEG, MAC_MDM};
  endfunction

  // CMP only produces flags/result; every other active op updates acc[sel].
  function automatic logic op_writes_acc(input logic [3:0] op);
    return op_active(op) && (op != MAC_CMP);
  endfunction

endpackage

// File: rtl/mac_round_sat.sv
// mac_round_sat
//   Combinational round-then-saturate stage of the MAC datapath.
//   Ports:
//     value_i      accumulator-width value entering the stage
//     round_i      add 2^(DATA_W-1) and clear the low DATA_W bits
//     sat_i        clamp to the 2*DATA_W signed range when guard bits disagree
//     value_o      processed value
//     sat_o        saturation happened
//     round_ovf_o  rounding carried into the sign bit
module mac_round_sat #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8,
  localparam int ACC_W  = 2*DATA_W + GUARD_W
) (
  input  logic [ACC_W-1:0] value_i,
  input  logic             round_i,
  input  logic             sat_i,
  output logic [ACC_W-1:0] value_o,
  output logic             sat_o,
  output logic             round_ovf_o
);

  localparam logic [ACC_W-1:0] ROUND_INC =
    {{(ACC_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] SAT_MAX =
    {{(GUARD_W+1){1'b0}}, {(2*DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN =
    {{(GUARD_W+1){1'b1}}, {(2*DATA_W-1){1'b0}}};

  logic [ACC_W-1:0]   rounded;
  logic [ACC_W-1:0]   pre_sat;
  logic [GUARD_W:0]   hi_bits;

  always_comb begin
    rounded              = value_i + ROUND_INC;
    rounded[DATA_W-1:0]  = '0;
    round_ovf_o          = round_i && !value_i[ACC_W-1] && rounded[ACC_W-1];
    pre_sat              = round_i ? rounded : value_i;

    // Guard bits plus the product sign bit must all agree to fit 2*DATA_W.
    hi_bits = pre_sat[ACC_W-1:2*DATA_W-1];
    value_o = pre_sat;
    sat_o   = 1'b0;
    if (sat_i && !((&hi_bits) || !(|hi_bits))) begin
      sat_o   = 1'b1;
      value_o = pre_sat[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mac_dp_multi.sv
// mac_dp_multi
//   Two-stage pipelined MAC datapath with NUM_ACC guarded accumulators and
//   per-accumulator sticky overflow flags.
//   Ports:
//     clk_i, reset_i          clock, asynchronous active-low reset
//     in_valid_i, stall_i     op present / freeze whole pipeline
//     c_macop, c_acc_sel      opcode and accumulator index
//     c_scalefactor, c_dosat  operand-B scaling, saturate enable
//     mul_opa_i, mul_opb_i    signed multiplier operands
//     operandb_i              register-file operand for non-multiply ops
//     result_o, result_valid_o, flags_o  registered result and
//                             {sat, scale_ovf, pos_ovf, neg_ovf}
//     sticky_ovf_o            sticky overflow bit per accumulator
module mac_dp_multi #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8,
  parameter int NUM_ACC = 4,
  localparam int ACC_W  = 2*DATA_W + GUARD_W,
  localparam int SEL_W  = $clog2(NUM_ACC)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  input  logic                     stall_i,
  input  logic [3:0]               c_macop,
  input  logic [SEL_W-1:0]         c_acc_sel,
  input  logic [2:0]               c_scalefactor,
  input  logic                     c_dosat,
  input  logic signed [DATA_W-1:0] mul_opa_i,
  input  logic signed [DATA_W-1:0] mul_opb_i,
  input  logic [ACC_W-1:0]         operandb_i,
  output logic [ACC_W-1:0]         result_o,
  output logic                     result_valid_o,
  output logic [3:0]               flags_o,
  output logic [NUM_ACC-1:0]       sticky_ovf_o
);

  import mac_dp_multi_pkg::*;

  localparam int PROD_W = 2*DATA_W;
  localparam logic [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  // E1 stage registers
  logic               e1_valid_q, e1_valid_d;
  logic [3:0]         e1_op_q, e1_op_d;
  logic [SEL_W-1:0]   e1_sel_q, e1_sel_d;
  logic [2:0]         e1_scale_q, e1_scale_d;
  logic               e1_dosat_q, e1_dosat_d;
  logic [ACC_W-1:0]   e1_opb_q, e1_opb_d;
  logic [ACC_W-1:0]   e1_prod_q, e1_prod_d;

  // E2 / architectural state
  logic [ACC_W-1:0]   acc_q [NUM_ACC];
  logic [ACC_W-1:0]   acc_d [NUM_ACC];
  logic [NUM_ACC-1:0] sticky_q, sticky_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [3:0]         flags_q, flags_d;

  // E2 datapath nets
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  b_sel, b_scaled;
  logic                     scale_ovf;
  logic [ACC_W-1:0]         opa, bb, sum, abs_val, final_val;
  logic                     add_pos_ovf, add_neg_ovf, abs_neg_ovf;
  logic                     sat_flag, round_ovf;
  logic [3:0]               flags_new;

  assign product = $signed({{DATA_W{mul_opa_i[DATA_W-1]}}, mul_opa_i}) *
                   $signed({{DATA_W{mul_opb_i[DATA_W-1]}}, mul_opb_i});

  // E1 capture: only an accepted op loads new controls; a stall freezes all.
  always_comb begin
    e1_valid_d = e1_valid_q;
    e1_op_d    = e1_op_q;
    e1_sel_d   = e1_sel_q;
    e1_scale_d = e1_scale_q;
    e1_dosat_d = e1_dosat_q;
    e1_opb_d   = e1_opb_q;
    e1_prod_d  = e1_prod_q;
    if (!stall_i) begin
      e1_valid_d = in_valid_i;
      if (in_valid_i) begin
        e1_op_d    = c_macop;
        e1_sel_d   = c_acc_sel;
        e1_scale_d = c_scalefactor;
        e1_dosat_d = c_dosat;
        e1_opb_d   = operandb_i;
        e1_prod_d  = {{GUARD_W{product[PROD_W-1]}}, product};
      end
    end
  end

  // B-select and scaling; a left shift overflows when the discarded MSBs
  // and the new sign bit are not all equal.
  always_comb begin
    b_sel = '0;
    if (op_uses_operandb(e1_op_q)) begin
      b_sel = e1_opb_q;
    end else if (op_uses_product(e1_op_q)) begin
      b_sel = e1_prod_q;
    end

    b_scaled  = b_sel;
    scale_ovf = 1'b0;
    case (e1_scale_q)
      SCALE_SHL1: begin
        b_scaled  = b_sel <<< 1;
        scale_ovf = !((&b_sel[ACC_W-1 -: 2]) || !(|b_sel[ACC_W-1 -: 2]));
      end
      SCALE_SHL2: begin
        b_scaled  = b_sel <<< 2;
        scale_ovf = !((&b_sel[ACC_W-1 -: 3]) || !(|b_sel[ACC_W-1 -: 3]));
      end
      SCALE_SHL3: begin
        b_scaled  = b_sel <<< 3;
        scale_ovf = !((&b_sel[ACC_W-1 -: 4]) || !(|b_sel[ACC_W-1 -: 4]));
      end
      SCALE_SHR1: b_scaled = b_sel >>> 1;
      SCALE_SHR2: b_scaled = b_sel >>> 2;
      SCALE_SHR3: b_scaled = b_sel >>> 3;
      SCALE_SHR4: b_scaled = b_sel >>> 4;
      default:    b_scaled = b_sel;
    endcase
  end

  // Adder with subtract-by-inversion, then ABS. Negating the most negative
  // value wraps to itself, which is reported as a negative overflow.
  always_comb begin
    opa         = op_reads_acc(e1_op_q) ? acc_q[e1_sel_q] : '0;
    bb          = op_inverts_b(e1_op_q) ? ~b_scaled : b_scaled;
    sum         = opa + bb + ACC_W'(op_inverts_b(e1_op_q));
    add_pos_ovf = !opa[ACC_W-1] && !bb[ACC_W-1] &&  sum[ACC_W-1];
    add_neg_ovf =  opa[ACC_W-1] &&  bb[ACC_W-1] && !sum[ACC_W-1];

    abs_val     = sum;
    abs_neg_ovf = 1'b0;
    if ((e1_op_q == MAC_ABS) && sum[ACC_W-1]) begin
      abs_val     = -sum;
      abs_neg_ovf = (sum == MOST_NEG);
    end
  end

  mac_round_sat #(
    .DATA_W  (DATA_W),
    .GUARD_W (GUARD_W)
  ) u_round_sat (
    .value_i     (abs_val),
    .round_i     (e1_op_q == MAC_MOVE_ROUND),
    .sat_i       (e1_dosat_q),
    .value_o     (final_val),
    .sat_o       (sat_flag),
    .round_ovf_o (round_ovf)
  );

  assign flags_new = {sat_flag, scale_ovf, add_pos_ovf | round_ovf,
                      add_neg_ovf | abs_neg_ovf};

  // E2 retire: result/flags hold across NOP and idle cycles; the accumulator
  // write lands on the same edge so the next op's E2 sees it directly.
  always_comb begin
    result_d       = result_q;
    flags_d        = flags_q;
    result_valid_d = result_valid_q;
    acc_d          = acc_q;
    sticky_d       = sticky_q;
    if (!stall_i) begin
      result_valid_d = e1_valid_q && op_active(e1_op_q);
      if (e1_valid_q && op_active(e1_op_q)) begin
        result_d = final_val;
        flags_d  = flags_new;
        if (op_writes_acc(e1_op_q)) begin
          acc_d[e1_sel_q]    = final_val;
          sticky_d[e1_sel_q] = (e1_op_q == MAC_CLR) ? 1'b0 :
                               (sticky_q[e1_sel_q] | (|flags_new[2:0]));
        end
      end
    end
  end

  // State register for both stages and the accumulator bank.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      e1_valid_q     <= 1'b0;
      e1_op_q        <= '0;
      e1_sel_q       <= '0;
      e1_scale_q     <= '0;
      e1_dosat_q     <= 1'b0;
      e1_opb_q       <= '0;
      e1_prod_q      <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      sticky_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      flags_q        <= '0;
    end else begin
      e1_valid_q     <= e1_valid_d;
      e1_op_q        <= e1_op_d;
      e1_sel_q       <= e1_sel_d;
      e1_scale_q     <= e1_scale_d;
      e1_dosat_q     <= e1_dosat_d;
      e1_opb_q       <= e1_opb_d;
      e1_prod_q      <= e1_prod_d;
      acc_q          <= acc_d;
      sticky_q       <= sticky_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      flags_q        <= flags_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign flags_o        = flags_q;
  assign sticky_ovf_o   = sticky_q;

endmodule

// File: tb/tb_mac_dp_multi.sv
// tb_mac_dp_multi
//   Directed-vector bench for mac_dp_multi at default parameters
//   (DATA_W=16, GUARD_W=8, NUM_ACC=4, 40-bit accumulators).
module tb_mac_dp_multi;

  import mac_dp_multi_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic        stall_i;
  logic [3:0]  c_macop;
  logic [1:0]  c_acc_sel;
  logic [2:0]  c_scalefactor;
  logic        c_dosat;
  logic [15:0] mul_opa_i;
  logic [15:0] mul_opb_i;
  logic [39:0] operandb_i;
  logic [39:0] result_o;
  logic        result_valid_o;
  logic [3:0]  flags_o;
  logic [3:0]  sticky_ovf_o;

  int vector_count = 0;
  int miss_count   = 0;

  mac_dp_multi dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .in_valid_i     (in_valid_i),
    .stall_i        (stall_i),
    .c_macop        (c_macop),
    .c_acc_sel      (c_acc_sel),
    .c_scalefactor  (c_scalefactor),
    .c_dosat        (c_dosat),
    .mul_opa_i      (mul_opa_i),
    .mul_opb_i      (mul_opb_i),
    .operandb_i     (operandb_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .flags_o        (flags_o),
    .sticky_ovf_o   (sticky_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [39:0] exp_result,
                             input logic [3:0] exp_flags);
    checkOutput({tag, "_valid"}, 64'(result_valid_o), 64'd1);
    checkOutput({tag, "_result"}, 64'(result_o), 64'(exp_result));
    checkOutput({tag, "_flags"}, 64'(flags_o), 64'(exp_flags));
  endtask

  // Presents one op and lets one clock edge accept it.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] sel,
                               input logic [2:0] scale, input logic dosat,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [39:0] opb);
    in_valid_i    = 1'b1;
    stall_i       = 1'b0;
    c_macop       = op;
    c_acc_sel     = sel;
    c_scalefactor = scale;
    c_dosat       = dosat;
    mul_opa_i     = a;
    mul_opb_i     = b;
    operandb_i    = opb;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drainCycle();
    in_valid_i = 1'b0;
    stall_i    = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i       = 1'b0;
    in_valid_i    = 1'b0;
    stall_i       = 1'b0;
    c_macop       = '0;
    c_acc_sel     = '0;
    c_scalefactor = '0;
    c_dosat       = 1'b0;
    mul_opa_i     = '0;
    mul_opb_i     = '0;
    operandb_i    = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state
    checkOutput("rst_valid", 64'(result_valid_o), 64'd0);
    checkOutput("rst_result", 64'(result_o), 64'd0);
    checkOutput("rst_flags", 64'(flags_o), 64'd0);
    checkOutput("rst_sticky", 64'(sticky_ovf_o), 64'd0);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Back-to-back MACs on acc1: 3*4 accumulated each cycle
    applyStimulus(MAC_MAC, 2'd1, 3'd0, 1'b0, 16'd3, 16'd4, '0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(MAC_MAC, 2'd1, 3'd0, 1'b0, 16'd3, 16'd4, '0);
      checkResult($sformatf("b2b%0d", i), 40'(12 * i), 4'b0000);
    end
    drainCycle();
    checkResult("b2b4", 40'd48, 4'b0000);
    drainCycle();
    checkOutput("b2b_idle_valid", 64'(result_valid_o), 64'd0);
    checkOutput("b2b_idle_hold", 64'(result_o), 64'd48);

    // Stall: op B held in E1 for 3 edges while op C waits at the input
    applyStimulus(MAC_MAC, 2'd3, 3'd0, 1'b0, 16'd2, 16'd5, '0);
    applyStimulus(MAC_MAC, 2'd3, 3'd0, 1'b0, 16'd2, 16'd5, '0);
    checkResult("stall_pre", 40'd10, 4'b0000);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      checkOutput("stall_frozen_valid", 64'(result_valid_o), 64'd1);
      checkOutput("stall_frozen_result", 64'(result_o), 64'd10);
    end
    stall_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkResult("stall_b", 40'd20, 4'b0000);
    drainCycle();
    checkResult("stall_c", 40'd30, 4'b0000);
    applyStimulus(MAC_MAC, 2'd3, 3'd0, 1'b0, 16'd0, 16'd0, '0);
    drainCycle();
    checkResult("stall_acc3", 40'd30, 4'b0000);

    // Saturation: 0x7FFF^2 accumulated three times on acc0
    for (int i = 0; i < 3; i++)
      applyStimulus(MAC_MAC, 2'd0, 3'd0, 1'b1, 16'h7FFF, 16'h7FFF, '0);
    drainCycle();
    checkResult("sat_on", 40'h007FFFFFFF, 4'b1000);
    checkOutput("sat_on_sticky", 64'(sticky_ovf_o[0]), 64'd0);
    applyStimulus(MAC_CLR, 2'd0, 3'd0, 1'b0, '0, '0, '0);
    drainCycle();
    checkResult("clr_acc0", 40'd0, 4'b0000);
    for (int i = 0; i < 3; i++)
      applyStimulus(MAC_MAC, 2'd0, 3'd0, 1'b0, 16'h7FFF, 16'h7FFF, '0);
    drainCycle();
    checkResult("sat_off", 40'h00BFFD0003, 4'b0000);

    // Signed overflow on ADD, then CLR clears the sticky bit
    applyStimulus(MAC_MOVE, 2'd2, 3'd0, 1'b0, '0, '0, 40'h7FFFFFFFFF);
    drainCycle();
    checkResult("move_max", 40'h7FFFFFFFFF, 4'b0000);
    applyStimulus(MAC_ADD, 2'd2, 3'd0, 1'b0, '0, '0, 40'd1);
    drainCycle();
    checkResult("add_ovf", 40'h8000000000, 4'b0010);
    checkOutput("add_ovf_sticky", 64'(sticky_ovf_o), 64'h4);
    applyStimulus(MAC_CLR, 2'd2, 3'd0, 1'b0, '0, '0, '0);
    drainCycle();
    checkResult("clr_acc2", 40'd0, 4'b0000);
    checkOutput("clr_acc2_sticky", 64'(sticky_ovf_o), 64'h0);

    // Round, ABS of most negative, left-scale overflow
    applyStimulus(MAC_MOVE_ROUND, 2'd1, 3'd0, 1'b0, '0, '0, 40'h0000018000);
    drainCycle();
    checkResult("round", 40'h0000020000, 4'b0000);
    applyStimulus(MAC_ABS, 2'd1, 3'd0, 1'b0, '0, '0, 40'h8000000000);
    drainCycle();
    checkResult("abs_min", 40'h8000000000, 4'b0001);
    applyStimulus(MAC_MOVE, 2'd2, 3'd1, 1'b0, '0, '0, 40'h4000000000);
    drainCycle();
    checkResult("scale_ovf", 40'h8000000000, 4'b0100);
    checkOutput("scale_sticky", 64'(sticky_ovf_o), 64'h6);

    // SUB / CMP (no write) / NEG / right scale / MDM / MUL
    applyStimulus(MAC_MOVE, 2'd3, 3'd0, 1'b0, '0, '0, 40'd100);
    applyStimulus(MAC_SUB, 2'd3, 3'd0, 1'b0, '0, '0, 40'd30);
    checkResult("move100", 40'd100, 4'b0000);
    applyStimulus(MAC_CMP, 2'd3, 3'd0, 1'b0, '0, '0, 40'd70);
    checkResult("sub", 40'd70, 4'b0000);
    applyStimulus(MAC_MAC, 2'd3, 3'd0, 1'b0, 16'd0, 16'd0, '0);
    checkResult("cmp", 40'd0, 4'b0000);
    drainCycle();
    checkResult("cmp_nowrite", 40'd70, 4'b0000);
    applyStimulus(MAC_NEG, 2'd0, 3'd0, 1'b0, '0, '0, 40'd5);
    drainCycle();
    checkResult("neg", 40'hFFFFFFFFFB, 4'b0000);
    applyStimulus(MAC_MOVE, 2'd0, 3'd5, 1'b0, '0, '0, 40'hFFFFFFFF00);
    drainCycle();
    checkResult("asr2", 40'hFFFFFFFFC0, 4'b0000);
    applyStimulus(MAC_MDM, 2'd0, 3'd0, 1'b0, 16'd2, 16'd3, '0);
    drainCycle();
    checkResult("mdm", 40'hFFFFFFFFBA, 4'b0000);
    applyStimulus(MAC_MUL, 2'd0, 3'd0, 1'b0, 16'hFFFD, 16'd7, '0);
    drainCycle();
    checkResult("mul_neg", 40'hFFFFFFFFEB, 4'b0000);
    checkOutput("misc_sticky", 64'(sticky_ovf_o), 64'h6);

    // NOP: no valid, result held
    applyStimulus(MAC_NOP, 2'd0, 3'd0, 1'b0, 16'd9, 16'd9, 40'd9);
    drainCycle();
    checkOutput("nop_valid", 64'(result_valid_o), 64'd0);
    checkOutput("nop_hold", 64'(result_o), 64'hFFFFFFFFEB);

    // Mid-operation reset discards the in-flight MAC
    applyStimulus(MAC_MAC, 2'd0, 3'd0, 1'b0, 16'd3, 16'd4, '0);
    reset_i    = 1'b0;
    in_valid_i = 1'b0;
    #2;
    checkOutput("midrst_valid", 64'(result_valid_o), 64'd0);
    checkOutput("midrst_result", 64'(result_o), 64'd0);
    checkOutput("midrst_sticky", 64'(sticky_ovf_o), 64'd0);
    #1;
    reset_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(MAC_MAC, 2'(k), 3'd0, 1'b0, 16'd0, 16'd0, '0);
      drainCycle();
      checkResult($sformatf("midrst_acc%0d", k), 40'd0, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
